// File: rtl/obi_bridge_pkg.sv
// rtl/obi_bridge_pkg.sv - shared types and default widths for the OBI burst bridge
package obi_bridge_pkg;

    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_ADDR_STRIDE = 4;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_BE_W        = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } bridge_state_e;

    typedef struct packed {
        logic [DEF_BE_W-1:0]   be;
        logic [DEF_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/bridge_wr_fifo.sv
// rtl/bridge_wr_fifo.sv - synchronous write-word FIFO with occupancy level
module bridge_wr_fifo
    import obi_bridge_pkg::*;
#(
    parameter int  DEPTH   = DEF_FIFO_DEPTH,
    parameter type entry_t = wr_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty differ.
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/obi_burst_bridge.sv
// rtl/obi_burst_bridge.sv - host-to-OBI master bridge: buffered streaming writes, single reads
// Read path is built only when BRIDGE_READ_EN is defined.
module obi_burst_bridge
    import obi_bridge_pkg::*;
#(
    parameter int  FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int  ADDR_STRIDE = DEF_ADDR_STRIDE,
    parameter int  ADDR_W      = DEF_ADDR_W,
    parameter int  DATA_W      = DEF_DATA_W,
    localparam int BE_W        = DATA_W / 8,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req,
    output logic              we,
    output logic [BE_W-1:0]   be,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              gnt,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              addr_ld,
    input  logic [ADDR_W-1:0] new_addr,
    input  logic              wr_push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_cmd,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ack,
    output logic              busy,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              err,
    input  logic              err_clr
);

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } entry_t;

    bridge_state_e     state_q;
    bridge_state_e     state_d;
    logic              cur_we_q;
    logic              cur_we_d;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic              busy_w;
    logic              rd_pend_q;
    logic              rd_done;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overflow;
    logic              ld_err;
    entry_t            push_entry;
    entry_t            head;

    assign push_entry = entry_t'{be: wr_be, data: wr_data};

    bridge_wr_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign busy_w = (state_q != IDLE) || !fifo_empty || rd_pend_q;
    assign busy   = busy_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_we_q <= cur_we_d;
        end
    end

    // A push seen in IDLE starts the write at once, giving req the cycle after the push.
    always_comb begin
        state_d  = state_q;
        cur_we_d = cur_we_q;
        fifo_pop = 1'b0;
        rd_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty || wr_push) begin
                    state_d  = REQ;
                    cur_we_d = 1'b1;
                end else if (rd_pend_q) begin
                    state_d  = REQ;
                    cur_we_d = 1'b0;
                end
            end
            REQ: begin
                if (gnt) begin
                    state_d  = RESP;
                    fifo_pop = cur_we_q;
                end
            end
            RESP: begin
                if (rvalid) begin
                    state_d = IDLE;
                    rd_done = !cur_we_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload comes straight from the FIFO head, which only moves on gnt.
    assign req   = (state_q == REQ);
    assign we    = req && cur_we_q;
    assign be    = !req ? '0 : (cur_we_q ? head.be : '1);
    assign wdata = we ? head.data : '0;
    assign addr  = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else if (addr_ld && !busy_w) begin
            addr_q <= new_addr;
        end else if ((state_q == REQ) && gnt) begin
            addr_q <= addr_q + ADDR_W'(ADDR_STRIDE);
        end
    end

    assign overflow = wr_push && fifo_full && !fifo_pop;
    assign ld_err   = addr_ld && busy_w;
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (err_q && !err_clr) || overflow || ld_err;
        end
    end

`ifdef BRIDGE_READ_EN
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // The pending flag stays up until the response so a second rd_cmd is ignored in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (rd_cmd && !rd_pend_q && !rd_valid_q) begin
                rd_pend_q <= 1'b1;
            end
            if (rd_done) begin
                rd_pend_q  <= 1'b0;
                rd_valid_q <= 1'b1;
                rd_data_q  <= rdata;
            end else if (rd_ack) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`else
    logic unused_rd;

    assign rd_pend_q = 1'b0;
    assign rd_valid  = 1'b0;
    assign rd_data   = '0;
    assign unused_rd = ^{rd_cmd, rd_ack, rdata, rd_done};
`endif

    // A response outside RESP is a slave protocol violation.
    assert property (@(posedge clk) disable iff (rst) rvalid |-> (state_q == RESP));

endmodule
